// File: rtl/alu_mul_seq_if.sv
// Request/response handshake bundle for alu_mul_seq: operands in, product out.
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low half) that borrows the core ALU for every add and shift.
// Optional early termination on a zero multiplier: define ALU_MUL_EARLY_EXIT_EN.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     req,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt
);

  localparam logic [2:0] CTRL_ADD  = 3'b000;
  localparam logic [2:0] CTRL_SHL  = 3'b010;
  localparam logic [2:0] CTRL_SHR  = 3'b100;
  localparam logic [2:0] CTRL_PASS = 3'b111;

`ifdef ALU_MUL_EARLY_EXIT_EN
  typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;

  // The ALU's less-than flag has no role in multiplication.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_lt ^ alu_zero;

  // Next-state and datapath update; every arithmetic result comes back through alu_result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req.in_valid) begin
          acc_d    = '0;
          mcand_d  = req.op_a;
          mplier_d = req.op_b;
          cnt_d    = 4'd0;
`ifdef ALU_MUL_EARLY_EXIT_EN
          state_d  = TEST;
`else
          state_d  = req.op_b[0] ? ADD : SHL;
`endif
        end
      end
`ifdef ALU_MUL_EARLY_EXIT_EN
      TEST: begin
        if (alu_zero) state_d = DONE;
        else          state_d = mplier_q[0] ? ADD : SHL;
      end
`endif
      ADD: begin
        acc_d   = alu_result;
        state_d = SHL;
      end
      SHL: begin
        mcand_d = alu_result;
        state_d = SHR;
      end
      SHR: begin
        mplier_d = alu_result;
        cnt_d    = cnt_q + 4'd1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        state_d  = TEST;
`else
        if (cnt_q == 4'd15) state_d = DONE;
        else                state_d = alu_result[0] ? ADD : SHL;
`endif
      end
      DONE: begin
        if (req.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with state_q.
  always_comb begin
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_ctrl_d = CTRL_PASS;
    unique case (state_d)
`ifdef ALU_MUL_EARLY_EXIT_EN
      TEST: begin
        alu_a_d    = mplier_d;
        alu_ctrl_d = CTRL_PASS;
      end
`endif
      ADD: begin
        alu_a_d    = acc_d;
        alu_b_d    = mcand_d;
        alu_ctrl_d = CTRL_ADD;
      end
      SHL: begin
        alu_a_d    = mcand_d;
        alu_b_d    = WIDTH'(1);
        alu_ctrl_d = CTRL_SHL;
      end
      SHR: begin
        alu_a_d    = mplier_d;
        alu_b_d    = WIDTH'(1);
        alu_ctrl_d = CTRL_SHR;
      end
      default: begin
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_ctrl_d = CTRL_PASS;
      end
    endcase
    out_valid_d = (state_d == DONE);
    product_d   = (state_d == DONE) ? acc_d : '0;
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= CTRL_PASS;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
    end
  end

  assign req.out_valid = out_valid_q;
  assign req.product   = product_q;
  assign req.in_ready  = in_ready_q;
  assign busy          = busy_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctrl      = alu_ctrl_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU and a product/latency reference model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_lt;

  alu_mul_seq_if #(.WIDTH(16)) req ();

  alu_mul_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_res),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt)
  );

  always #5 clk = ~clk;

  // Stand-in for the core ALU.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_res = alu_a + alu_b;
      3'b010:  alu_res = alu_a << alu_b;
      3'b100:  alu_res = alu_a >> alu_b;
      3'b111:  alu_res = alu_a;
      default: alu_res = 16'h0000;
    endcase
    alu_zero = (alu_res == 16'h0000);
    alu_lt   = ($signed(alu_a) < $signed(alu_b));
  end

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random stalls, 2: never ready

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] b);
    int k = 0;
    int p = 0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        p++;
        k = i + 1;
      end
    end
`ifdef ALU_MUL_EARLY_EXIT_EN
    return 3 * k + p + 1;
`else
    return 32 + p;
`endif
  endfunction

  initial begin : ready_driver
    req.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       req.out_ready = ($urandom_range(0, 3) != 0);
        2:       req.out_ready = 1'b0;
        default: req.out_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    bit          in_txn = 1'b0;
    logic [15:0] held = 16'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 1'b0;
      end else if (req.out_valid) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          held   = req.product;
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check("product", int'(req.product), int'(e.prod));
            check("latency", cyc - e.cyc, e.lat);
          end
        end else begin
          check("product_held", int'(req.product), int'(held));
        end
        if (req.out_ready) in_txn = 1'b0;
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  // Issue one request; with trace set, also follow the ALU opcode stream until out_valid.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit trace);
    int         n;
    logic [2:0] exp_seq[$];
    logic [2:0] obs_seq[$];
    int         mism;
    bit         bad_b;
    n = 0;
    @(negedge clk);
    while (!req.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req.in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    req.in_valid = 1'b1;
    req.op_a     = a;
    req.op_b     = b;
    @(posedge clk);
    #1;
    sb.push_back('{prod: 16'(32'(a) * 32'(b)), lat: exp_latency(b), cyc: cyc});
    req.in_valid = 1'b0;
    if (trace) begin
`ifdef ALU_MUL_EARLY_EXIT_EN
      begin
        int k = 0;
        for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
        for (int i = 0; i < k; i++) begin
          exp_seq.push_back(3'b111);
          if (b[i]) exp_seq.push_back(3'b000);
          exp_seq.push_back(3'b010);
          exp_seq.push_back(3'b100);
        end
        exp_seq.push_back(3'b111);
      end
`else
      for (int i = 0; i < 16; i++) begin
        if (b[i]) exp_seq.push_back(3'b000);
        exp_seq.push_back(3'b010);
        exp_seq.push_back(3'b100);
      end
`endif
      bad_b = 1'b0;
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (req.out_valid) break;
        obs_seq.push_back(alu_ctrl);
        if ((alu_ctrl == 3'b010 || alu_ctrl == 3'b100) && alu_b != 16'd1) bad_b = 1'b1;
        n++;
      end
      check("ctrl_seq_len", obs_seq.size(), exp_seq.size());
      mism = 0;
      for (int i = 0; i < obs_seq.size() && i < exp_seq.size(); i++)
        if (obs_seq[i] != exp_seq[i]) mism++;
      check("ctrl_seq", mism, 0);
      check("shift_amount", int'(bad_b), 0);
    end
  endtask

  initial begin : stimulus
    int          n;
    logic [15:0] mask, ra, rb;
    req.in_valid = 1'b0;
    req.op_a     = 16'h0;
    req.op_b     = 16'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(req.out_valid), 0);
    check("rst_product", int'(req.product), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(req.in_ready), 1);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_ctrl", int'(alu_ctrl), 7);
    rst_n = 1'b1;

    issue(16'd3, 16'd5, 1'b1);
    issue(16'h1234, 16'h0000, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    issue(16'hABCD, 16'h0001, 1'b1);

    // Back-pressure: product must hold while stray requests are refused.
    ready_mode = 2;
    issue(16'd3, 16'd5, 1'b0);
    n = 0;
    while (!req.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_reach_done", int'(req.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req.in_valid = 1'b1;
      req.op_a     = 16'($urandom);
      req.op_b     = 16'($urandom);
      check("hold_out_valid", int'(req.out_valid), 1);
      check("hold_product", int'(req.product), 15);
      check("hold_in_ready", int'(req.in_ready), 0);
    end
    @(negedge clk);
    req.in_valid = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #1;
    check("release_in_ready", int'(req.in_ready), 1);
    check("release_out_valid", int'(req.out_valid), 0);
    issue(16'd9, 16'd11, 1'b0);

    // Asynchronous reset in the middle of a shift.
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    n = 0;
    while (alu_ctrl != 3'b010 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_shl", int'(alu_ctrl), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(req.out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(req.in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd7, 16'd6, 1'b0);

    // Randomised traffic with random consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 30; i++) begin
      mask = 16'hFFFF >> $urandom_range(0, 16);
      ra   = 16'($urandom);
      rb   = 16'($urandom) & mask;
      issue(ra, rb, (i % 6) == 0);
    end
    ready_mode = 0;

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
